hyperbus_ddr_tx: RTL and testbench

Transmit-side DDR serializer for the HyperBus PHY write path. It accepts 16-bit words with per-byte strobes over a valid/ready handshake and buffers them in a 2-entry FIFO. It drives the 8-bit DQ bus at double data rate: high byte in the clk_i-high phase, low byte in the clk_i-low phase. RWDS carries the byte mask. It is the launch counterpart of the PHY's DDR capture stage, whose output bit [1] is the posedge sample and bit [0] the negedge sample.

---
 rtl/hyperbus_ddr_tx.sv | 182 ++++++++++++++++++
 tb/tb_hyperbus_ddr_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_ddr_tx.sv
// HyperBus PHY write-path DDR serializer: 2-entry word FIFO feeding a posedge
// launch register, with the low byte re-timed onto the negedge for DQ/RWDS.
module hyperbus_ddr_tx #(
    parameter int NUM_LANES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [2*NUM_LANES-1:0] tx_data_i,
    input  logic [1:0]             tx_strb_i,
    input  logic                   tx_last_i,
    input  logic                   tx_valid_i,
    output logic                   tx_ready_o,
    output logic [NUM_LANES-1:0]   dq_o,
    output logic                   rwds_o,
    output logic                   dq_oe_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   underrun_o,
    output logic [15:0]            burst_len_o
);
    localparam int W = 2 * NUM_LANES;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e state;

    logic [W-1:0] fifo_data [2];
    logic [1:0]   fifo_strb [2];
    logic [1:0]   fifo_last;
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         fifo_empty;
    logic         push;
    logic         pop;

    logic [W-1:0] head_data;
    logic [1:0]   head_strb;
    logic         head_last;

    logic [NUM_LANES-1:0] launch_hi;
    logic [NUM_LANES-1:0] launch_lo;
    logic                 launch_mhi;
    logic                 launch_mlo;
    logic                 launch_last;
    logic                 launch_oe;

    logic [NUM_LANES-1:0] neg_lo;
    logic                 neg_mlo;

    assign fifo_empty = (count == 2'd0);
    assign tx_ready_o = (count < 2'd2) && !clear_i;
    assign push       = tx_valid_i && tx_ready_o;
    // The retiring cycle of a last word never pops, forcing an idle gap between bursts.
    assign pop        = !clear_i && !fifo_empty && (state == IDLE || !launch_last);

    assign head_data = fifo_data[rd_ptr];
    assign head_strb = fifo_strb[rd_ptr];
    assign head_last = fifo_last[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_strb[i] <= '0;
            end
            fifo_last <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else if (clear_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= tx_data_i;
                fifo_strb[wr_ptr] <= tx_strb_i;
                fifo_last[wr_ptr] <= tx_last_i;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            launch_hi   <= '0;
            launch_lo   <= '0;
            launch_mhi  <= 1'b0;
            launch_mlo  <= 1'b0;
            launch_last <= 1'b0;
            launch_oe   <= 1'b0;
            done_o      <= 1'b0;
            underrun_o  <= 1'b0;
            burst_len_o <= '0;
        end else if (clear_i) begin
            state       <= IDLE;
            launch_hi   <= '0;
            launch_lo   <= '0;
            launch_mhi  <= 1'b0;
            launch_mlo  <= 1'b0;
            launch_last <= 1'b0;
            launch_oe   <= 1'b0;
            done_o      <= 1'b0;
            underrun_o  <= 1'b0;
            burst_len_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        launch_hi   <= head_data[W-1:NUM_LANES];
                        launch_lo   <= head_data[NUM_LANES-1:0];
                        launch_mhi  <= ~head_strb[1];
                        launch_mlo  <= ~head_strb[0];
                        launch_last <= head_last;
                        launch_oe   <= 1'b1;
                        burst_len_o <= 16'd1;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (launch_last) begin
                        launch_hi   <= '0;
                        launch_lo   <= '0;
                        launch_mhi  <= 1'b0;
                        launch_mlo  <= 1'b0;
                        launch_last <= 1'b0;
                        launch_oe   <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= IDLE;
                    end else if (!fifo_empty) begin
                        launch_hi   <= head_data[W-1:NUM_LANES];
                        launch_lo   <= head_data[NUM_LANES-1:0];
                        launch_mhi  <= ~head_strb[1];
                        launch_mlo  <= ~head_strb[0];
                        launch_last <= head_last;
                        launch_oe   <= 1'b1;
                        if (burst_len_o != 16'hFFFF) begin
                            burst_len_o <= burst_len_o + 16'd1;
                        end
                    end else begin
                        // Starved mid-burst: keep the bus driven with a fully masked filler.
                        launch_hi   <= '0;
                        launch_lo   <= '0;
                        launch_mhi  <= 1'b1;
                        launch_mlo  <= 1'b1;
                        launch_last <= 1'b0;
                        launch_oe   <= 1'b1;
                        underrun_o  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Low byte and its mask are re-timed so they stay stable for the whole low phase.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            neg_lo  <= '0;
            neg_mlo <= 1'b0;
        end else begin
            neg_lo  <= launch_lo;
            neg_mlo <= launch_mlo;
        end
    end

    assign dq_o    = clk_i ? launch_hi : neg_lo;
    assign rwds_o  = clk_i ? launch_mhi : neg_mlo;
    assign dq_oe_o = launch_oe;
    assign busy_o  = (state == ACTIVE);

endmodule

// File: tb/tb_hyperbus_ddr_tx.sv
// Self-checking bench for hyperbus_ddr_tx: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_hyperbus_ddr_tx;
    localparam int NUM_LANES = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic [15:0] tx_data_i = '0;
    logic [1:0]  tx_strb_i = '0;
    logic        tx_last_i = 1'b0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  dq_o;
    logic        rwds_o;
    logic        dq_oe_o;
    logic        busy_o;
    logic        done_o;
    logic        underrun_o;
    logic [15:0] burst_len_o;

    hyperbus_ddr_tx #(.NUM_LANES(NUM_LANES)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .tx_data_i   (tx_data_i),
        .tx_strb_i   (tx_strb_i),
        .tx_last_i   (tx_last_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .dq_o        (dq_o),
        .rwds_o      (rwds_o),
        .dq_oe_o     (dq_oe_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .underrun_o  (underrun_o),
        .burst_len_o (burst_len_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  strb;
        logic        last;
    } word_t;

    int error_count = 0;
    int check_count = 0;

    // Model: queued words plus the word currently on the bus.
    word_t       model_q[$];
    logic        model_active;
    logic [15:0] cur_data;
    logic [1:0]  cur_mask;
    logic        cur_last;
    logic        cur_oe;
    logic        exp_done;
    logic        exp_under;
    logic [15:0] exp_len;

    logic [7:0]  obs_hi, obs_lo;
    logic        obs_rwds_hi, obs_rwds_lo, obs_oe, obs_busy, obs_done, obs_under, obs_ready;
    logic [15:0] obs_len;
    logic [7:0]  dq_seq[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_active = 1'b0;
        cur_data     = '0;
        cur_mask     = '0;
        cur_last     = 1'b0;
        cur_oe       = 1'b0;
        exp_done     = 1'b0;
        exp_under    = 1'b0;
        exp_len      = '0;
    endtask

    task automatic modelStep(input logic valid, input word_t w, input logic clr);
        logic  accept;
        word_t head;
        if (clr) begin
            modelReset();
        end else begin
            accept   = valid && (model_q.size() < 2);
            exp_done = 1'b0;
            if (model_q.size() > 0 && (!model_active || !cur_last)) begin
                head     = model_q.pop_front();
                cur_data = head.data;
                cur_mask = ~head.strb;
                cur_last = head.last;
                cur_oe   = 1'b1;
                exp_len  = !model_active ? 16'd1 : (exp_len == 16'hFFFF ? exp_len : exp_len + 16'd1);
                model_active = 1'b1;
            end else if (model_active && cur_last) begin
                {cur_data, cur_mask, cur_last, cur_oe} = '0;
                exp_done     = 1'b1;
                model_active = 1'b0;
            end else if (model_active) begin
                cur_data  = 16'h0000;
                cur_mask  = 2'b11;
                cur_last  = 1'b0;
                cur_oe    = 1'b1;
                exp_under = 1'b1;
            end
            if (accept) model_q.push_back(w);
        end
    endtask

    // One clk_i period: drive inputs in the low phase, sample both phases after the edges.
    task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic [1:0] strb,
                                 input logic last, input logic clr);
        tx_valid_i = valid;
        tx_data_i  = data;
        tx_strb_i  = strb;
        tx_last_i  = last;
        clear_i    = clr;
        @(posedge clk_i);
        modelStep(valid, {data, strb, last}, clr);
        #1;
        obs_hi = dq_o;  obs_rwds_hi = rwds_o; obs_oe = dq_oe_o; obs_busy = busy_o;
        obs_done = done_o; obs_under = underrun_o; obs_len = burst_len_o; obs_ready = tx_ready_o;
        checkOutput("dq_hi", dq_o, cur_data[15:8]);
        checkOutput("rwds_hi", rwds_o, cur_mask[1]);
        checkOutput("dq_oe", dq_oe_o, cur_oe);
        checkOutput("busy", busy_o, model_active);
        checkOutput("done", done_o, exp_done);
        checkOutput("underrun", underrun_o, exp_under);
        checkOutput("burst_len", burst_len_o, exp_len);
        checkOutput("tx_ready", tx_ready_o, (model_q.size() < 2) && !clr);
        @(negedge clk_i);
        #1;
        obs_lo = dq_o; obs_rwds_lo = rwds_o;
        checkOutput("dq_lo", dq_o, cur_data[7:0]);
        checkOutput("rwds_lo", rwds_o, cur_mask[0]);
        if (obs_oe) begin
            dq_seq.push_back(obs_hi);
            dq_seq.push_back(obs_lo);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        #1;
        checkOutput("reset_dq", dq_o, 8'h00);
        checkOutput("reset_rwds", rwds_o, 1'b0);
        checkOutput("reset_oe", dq_oe_o, 1'b0);
        checkOutput("reset_busy", busy_o, 1'b0);
        checkOutput("reset_done", done_o, 1'b0);
        checkOutput("reset_under", underrun_o, 1'b0);
        checkOutput("reset_len", burst_len_o, 16'd0);
        checkOutput("reset_ready", tx_ready_o, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;

        // Single word
        applyStimulus(1'b1, 16'hA55A, 2'b11, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
        checkOutput("single_hi", obs_hi, 8'hA5);
        checkOutput("single_lo", obs_lo, 8'h5A);
        checkOutput("single_rwds", obs_rwds_hi, 1'b0);
        checkOutput("single_oe", obs_oe, 1'b1);
        applyStimulus(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
        checkOutput("single_oe_off", obs_oe, 1'b0);
        checkOutput("single_done", obs_done, 1'b1);
        checkOutput("single_len", obs_len, 16'd1);
        idleCycles(1);

        // Back-to-back burst of four words
        dq_seq.delete();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, {8'(2*i+1), 8'(2*i+2)}, 2'b11, i == 3, 1'b0);
        idleCycles(3);
        checkOutput("b2b_count", dq_seq.size(), 8);
        for (int k = 0; k < 8 && k < dq_seq.size(); k++)
            checkOutput($sformatf("b2b_dq%0d", k), dq_seq[k], k + 1);
        checkOutput("b2b_len", obs_len, 16'd4);
        checkOutput("b2b_under", obs_under, 1'b0);

        // Byte masking
        applyStimulus(1'b1, 16'h1234, 2'b01, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
        checkOutput("mask01_hi", obs_rwds_hi, 1'b1);
        checkOutput("mask01_lo", obs_rwds_lo, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 16'h1234, 2'b10, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
        checkOutput("mask10_hi", obs_rwds_hi, 1'b0);
        checkOutput("mask10_lo", obs_rwds_lo, 1'b1);
        idleCycles(2);

        // Full FIFO, then underrun in a three-word burst
        applyStimulus(1'b1, 16'h1111, 2'b11, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h2222, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h3333, 2'b11, 1'b0, 1'b0);
        checkOutput("full_ready", obs_ready, 1'b0);
        idleCycles(3);
        checkOutput("fill_hi", obs_hi, 8'h00);
        checkOutput("fill_lo", obs_lo, 8'h00);
        checkOutput("fill_rwds_hi", obs_rwds_hi, 1'b1);
        checkOutput("fill_rwds_lo", obs_rwds_lo, 1'b1);
        checkOutput("fill_under", obs_under, 1'b1);
        checkOutput("fill_oe", obs_oe, 1'b1);
        applyStimulus(1'b1, 16'h4444, 2'b11, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("under_done", obs_done, 1'b1);
        checkOutput("under_len", obs_len, 16'd3);
        checkOutput("under_sticky", obs_under, 1'b1);
        idleCycles(1);

        // Clear mid-burst
        applyStimulus(1'b1, 16'h5555, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h6666, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h7777, 2'b11, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h8888, 2'b11, 1'b0, 1'b1);
        checkOutput("clr_oe", obs_oe, 1'b0);
        checkOutput("clr_busy", obs_busy, 1'b0);
        checkOutput("clr_under", obs_under, 1'b0);
        checkOutput("clr_done", obs_done, 1'b0);
        checkOutput("clr_len", obs_len, 16'd0);
        applyStimulus(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
        checkOutput("clr_ready", obs_ready, 1'b1);
        checkOutput("clr_no_done", obs_done, 1'b0);

        // Asynchronous reset in the low phase of an active burst
        applyStimulus(1'b1, 16'h9A9B, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBCBD, 2'b10, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_dq", dq_o, 8'h00);
        checkOutput("arst_rwds", rwds_o, 1'b0);
        checkOutput("arst_oe", dq_oe_o, 1'b0);
        checkOutput("arst_busy", busy_o, 1'b0);
        checkOutput("arst_len", burst_len_o, 16'd0);
        checkOutput("arst_ready", tx_ready_o, 1'b1);
        tx_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("arst_hold_dq", dq_o, 8'h00);
        checkOutput("arst_hold_done", done_o, 1'b0);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        modelReset();

        // Randomized traffic with varying push density
        for (int seg = 0; seg < 4; seg++) begin
            for (int n = 0; n < 100; n++) begin
                applyStimulus($urandom_range(0, 9) < (3 + 2 * seg),
                              16'($urandom),
                              2'($urandom_range(0, 3)),
                              $urandom_range(0, 3) == 0,
                              $urandom_range(0, 49) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end
endmodule
